// File: rtl/jk_mod_counter_if.sv
// Control and observation bundle for the JK modulo counter.
// The master side drives the count controls; the slave side is the counter itself.
interface jk_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             tc;

    modport master (
        output en, up, load, load_val,
        input  q, qbar, j_out, k_out, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output q, qbar, j_out, k_out, tc
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MOD counter built from WIDTH JK stages driven with toggle excitation.
// The target value is decided combinationally and converted to per-stage J/K drive.
module jk_mod_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input logic             clk,
    input logic             rst_n,
    jk_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic             at_top;
    logic             at_zero;
    logic             illegal;
    logic             load_ok;
    logic             tc_c;

    assign at_top  = (q_r == TOP);
    assign at_zero = (q_r == ZERO);
    assign illegal = (32'(q_r) >= MOD);
    assign load_ok = (32'(bus.load_val) < MOD);

    // Target value: load beats count, out-of-range loads and states fall back toward 0.
    always_comb begin
        nxt = q_r;
        if (bus.load) begin
            nxt = load_ok ? bus.load_val : ZERO;
        end else if (bus.en) begin
            if (bus.up) begin
                nxt = (at_top || illegal) ? ZERO : q_r + ONE;
            end else begin
                nxt = at_zero ? TOP : q_r - ONE;
            end
        end
    end

    // Toggle only the stages that must change; J and K are never split.
    always_comb begin
        j_c = ZERO;
        k_c = ZERO;
        if (rst_n) begin
            j_c = q_r ^ nxt;
            k_c = q_r ^ nxt;
        end
    end

    assign tc_c = rst_n & bus.en & ~bus.load
                & ((bus.up & at_top) | (~bus.up & at_zero));

    // Bank of JK stages: each bit follows Q+ = J & ~Q | ~K & Q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= ZERO;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                q_r[i] <= (j_c[i] & ~q_r[i]) | (~k_c[i] & q_r[i]);
            end
        end
    end

    assign bus.q     = q_r;
    assign bus.qbar  = ~q_r;
    assign bus.j_out = j_c;
    assign bus.k_out = k_c;
    assign bus.tc    = tc_c;
endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous up/down modulo-N counter built as a bank of WIDTH JK flip-flop stages driven by toggle-style excitation.
- Per bit, J = K = 1 toggles and J = K = 0 holds.
- It is the stage directly downstream of the single JK flip-flop: it instantiates the JK next-state rule per bit and generates the J/K drive for each stage.
- Exposes the excitation vectors for debug and provides a terminal-count pulse for cascading.

Parameters:
- WIDTH, 4, number of counter bits (JK stages).
- MOD, 10, count modulus; legal range 2 to 2^WIDTH; count sequence is 0 to MOD-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; takes priority over en.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered count (JK stage Q outputs).
- qbar  output  WIDTH  bitwise complement of q.
- j_out  output  WIDTH  J excitation currently applied to each stage (combinational).
- k_out  output  WIDTH  K excitation currently applied to each stage (combinational).
- tc  output  1  terminal count, combinational.

Behaviour:
- Reset: when rst_n goes low, q = 0 and qbar = all ones immediately, with no clock needed.
- While rst_n is low: j_out = 0, k_out = 0, tc = 0, and all inputs are ignored.
- First clock edge after rst_n rises acts normally.
- Per-stage update at each rising clk: Q+ = (J & ~Q) | (~K & Q).
  - q must only ever change through this rule.
  - No direct register assignment except reset.
- Target next value nxt, by priority:
  - load = 1: nxt = load_val if load_val < MOD, else nxt = 0. Applies regardless of en and up.
  - load = 0, en = 1, up = 1: nxt = 0 if q == MOD-1, else q+1.
  - load = 0, en = 1, up = 0: nxt = MOD-1 if q == 0, else q-1.
  - load = 0, en = 0: nxt = q (hold).
- Excitation: j_out[i] = k_out[i] = q[i] ^ nxt[i].
  - Toggle where the bit must change, hold otherwise.
  - J and K are always equal; a stage is never driven to set-only or reset-only.
- Latency: one clock; q reflects nxt after the edge at which the inputs were sampled.
- Count width: arithmetic is WIDTH bits, with no carry out beyond tc.
- Illegal states (q >= MOD): reachable only via X or injection.
  - Up: next = 0.
  - Down: next = q-1.
  - Must not lock up.
- tc = en & ~load & rst_n & ((up & q == MOD-1) | (~up & q == 0)).
  - Asserted for exactly the cycle preceding a wrap.
- Simultaneous load and en: load wins, and tc = 0 in that cycle.
- Direction change mid-count takes effect on the next edge, with no extra cycle.
- Reset asserted mid-count clears q asynchronously, without waiting for the edge; counting restarts from 0.
- qbar == ~q at all times, including during reset.

Test Plan:
- Reset, then en = 1, up = 1, MOD = 10, 12 clocks.
  - q sequence 1,2,...,9,0,1,2.
  - tc = 1 only while q = 9.
  - At q 7->8 (0111->1000): j_out = k_out = 4'b1111.
- Down-count from reset, en = 1, up = 0.
  - q sequence 9,8,...,0,9.
  - tc = 1 only while q = 0; at q 0->9: j_out = k_out = 4'b1001.
- Load edge cases.
  - load = 1, load_val = 6, en = 1 → q = 6, tc = 0.
  - load_val = 12 → q = 0.
  - load = 0, en = 0 for 3 clocks → q holds at 0, j_out = k_out = 0.
- Direction reversal: count up to 5, then set up = 0 → q goes 4,3 on the next two edges.
- Async reset mid-count: at q = 7, pull rst_n low between edges.
  - q = 0 and qbar = 4'hF before the next edge; tc = 0, j_out = k_out = 0.
  - Release rst_n → counting resumes 1,2,...
- WIDTH = 3, MOD = 8 full wrap up: q goes 0..7,0; tc at 7; at 7->0, j_out = k_out = 3'b111.
